// File: rtl/link_partner.sv
// Link-cable partner: 8-bit MSB-first serial exchange, as SCK master or as a follower of DMG SCK.
// Optional slave-mode abort on SCK silence is enabled by defining LINK_PARTNER_TIMEOUT_EN.
module link_partner #(
  parameter int unsigned HALF_DIV = 256,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic       clk1,
  input  logic       nrst,
  input  logic       start,
  input  logic       master,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       lnk_si,
  output logic       lnk_so,
  input  logic       lnk_sck_i,
  output logic       lnk_sck_o,
  output logic       lnk_sck_oe
);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  localparam logic [15:0] HalfLoad = 16'(HALF_DIV - 1);

  state_e      state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic        master_q;
  logic [15:0] half_cnt_q;
  logic [1:0]  sync_q;
  logic        sck_prev_q;
  logic        seen_fall_q;
  logic [7:0]  rx_byte_q;
  logic        err_q;
  logic        so_q;
  logic        sck_o_q;
  logic        sck_oe_q;

  logic sck_fall;
  logic sck_rise;

`ifdef LINK_PARTNER_TIMEOUT_EN
  localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign sck_fall = sck_prev_q & ~sync_q[1];
  assign sck_rise = ~sck_prev_q & sync_q[1];

  always_ff @(posedge clk1 or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      master_q    <= 1'b0;
      half_cnt_q  <= 16'd0;
      sync_q      <= 2'b11;
      sck_prev_q  <= 1'b1;
      seen_fall_q <= 1'b0;
      rx_byte_q   <= 8'h00;
      err_q       <= 1'b0;
      so_q        <= 1'b1;
      sck_o_q     <= 1'b1;
      sck_oe_q    <= 1'b0;
`ifdef LINK_PARTNER_TIMEOUT_EN
      to_cnt_q    <= 16'd0;
`endif
    end else begin
      sync_q     <= {sync_q[0], lnk_sck_i};
      sck_prev_q <= sync_q[1];
      err_q      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            shift_q     <= tx_byte;
            bit_cnt_q   <= 3'd0;
            master_q    <= master;
            seen_fall_q <= 1'b0;
            half_cnt_q  <= HalfLoad;
            state_q     <= StLow;
`ifdef LINK_PARTNER_TIMEOUT_EN
            to_cnt_q    <= 16'd0;
`endif
            // Entering LOW as master is itself the first SCK fall.
            if (master) begin
              so_q     <= tx_byte[7];
              sck_o_q  <= 1'b0;
              sck_oe_q <= 1'b1;
            end
          end
        end
        StLow, StHigh: begin
          if (master_q) begin
            if (half_cnt_q != 16'd0) begin
              half_cnt_q <= half_cnt_q - 16'd1;
            end else begin
              half_cnt_q <= HalfLoad;
              if (state_q == StLow) begin
                state_q   <= StHigh;
                sck_o_q   <= 1'b1;
                shift_q   <= {shift_q[6:0], lnk_si};
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end else if (bit_cnt_q == 3'd0) begin
                // Counter wrapped: the 8th high phase has just ended.
                state_q   <= StDone;
                rx_byte_q <= shift_q;
                sck_oe_q  <= 1'b0;
              end else begin
                state_q <= StLow;
                sck_o_q <= 1'b0;
                so_q    <= shift_q[7];
              end
            end
          end else begin
`ifdef LINK_PARTNER_TIMEOUT_EN
            if (sck_fall || sck_rise) begin
              to_cnt_q <= 16'd0;
            end else begin
              to_cnt_q <= to_cnt_q + 16'd1;
            end
`endif
            if (sck_fall) begin
              so_q        <= shift_q[7];
              seen_fall_q <= 1'b1;
              state_q     <= StLow;
            end else if (sck_rise && seen_fall_q) begin
              shift_q   <= {shift_q[6:0], lnk_si};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q   <= StDone;
                rx_byte_q <= {shift_q[6:0], lnk_si};
              end else begin
                state_q <= StHigh;
              end
            end
`ifdef LINK_PARTNER_TIMEOUT_EN
            else if (!sck_rise && to_cnt_q == ToLast) begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
`endif
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_byte    = rx_byte_q;
  assign busy       = (state_q == StLow) || (state_q == StHigh);
  assign done       = (state_q == StDone);
  assign err        = err_q;
  assign lnk_so     = so_q;
  assign lnk_sck_o  = sck_o_q;
  assign lnk_sck_oe = sck_oe_q;

endmodule

// File: tb/tb_link_partner.sv
// Self-checking bench for link_partner; a behavioural DMG model plays the other cable end.
// Define LINK_PARTNER_TIMEOUT_EN for both files to exercise the slave abort path.
module tb_link_partner;
  localparam int unsigned HalfDiv    = 4;
  localparam int unsigned TimeoutCyc = 100;
  localparam int          SlaveHalf  = 20;

  logic       clk1 = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       master = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic [7:0] rx_byte;
  logic       busy, done, err;
  logic       lnk_si = 1'b1;
  logic       lnk_so;
  logic       lnk_sck_i = 1'b1;
  logic       lnk_sck_o, lnk_sck_oe;

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [7:0] exp_rx = 8'h00;  // model: last byte the partner should hold
  logic       dmg_m_en = 1'b0;
  logic [7:0] dmg_tx = 8'h00;
  logic [7:0] dmg_rx = 8'h00;

  link_partner #(.HALF_DIV(HalfDiv), .TIMEOUT(TimeoutCyc)) dut (
    .clk1      (clk1),
    .nrst      (nrst),
    .start     (start),
    .master    (master),
    .tx_byte   (tx_byte),
    .rx_byte   (rx_byte),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .lnk_si    (lnk_si),
    .lnk_so    (lnk_so),
    .lnk_sck_i (lnk_sck_i),
    .lnk_sck_o (lnk_sck_o),
    .lnk_sck_oe(lnk_sck_oe)
  );

  always #5 clk1 = ~clk1;

  // DMG as follower of the partner's SCK: shift out on fall, capture on rise.
  always @(negedge lnk_sck_o) if (dmg_m_en) begin
    lnk_si = dmg_tx[7];
    dmg_tx = {dmg_tx[6:0], 1'b0};
  end
  always @(posedge lnk_sck_o) if (dmg_m_en) dmg_rx = {dmg_rx[6:0], lnk_so};

  always @(negedge clk1) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic kick(input logic m, input logic [7:0] tx);
    @(negedge clk1);
    master = m; tx_byte = tx; start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(posedge clk1); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk1);
    n_total++;
    if ({busy, done, err} !== 3'b000) $display("FAIL reset_flags: got %b required 000", {busy, done, err});
    else n_pass++;
    n_total++;
    if (rx_byte !== 8'h00) $display("FAIL reset_rx: got %h required 00", rx_byte);
    else n_pass++;
    n_total++;
    if ({lnk_so, lnk_sck_o, lnk_sck_oe} !== 3'b110)
      $display("FAIL reset_pins: got %b required 110", {lnk_so, lnk_sck_o, lnk_sck_oe});
    else n_pass++;
    nrst = 1'b1;
    repeat (2) @(negedge clk1);
  endtask

  task automatic test_master(input logic [7:0] tx, input logic [7:0] dtx);
    int n;
    dmg_tx = dtx; dmg_rx = 8'h00; dmg_m_en = 1'b1;
    kick(1'b1, tx);
    n_total++;
    if ({busy, lnk_sck_oe, lnk_sck_o} !== 3'b110)
      $display("FAIL master_drive: got %b required 110", {busy, lnk_sck_oe, lnk_sck_o});
    else n_pass++;
    wait_done(200, n);
    n_total++;
    if (n < 64 || n > 66) $display("FAIL master_latency: got %0d required 64..66", n);
    else n_pass++;
    n_total++;
    if (rx_byte !== dtx) $display("FAIL master_rx: got %h required %h", rx_byte, dtx);
    else n_pass++;
    n_total++;
    if (dmg_rx !== tx) $display("FAIL master_dmg_rx: got %h required %h", dmg_rx, tx);
    else n_pass++;
    exp_rx = dtx;
    @(posedge clk1); #1;
    n_total++;
    if ({done, busy, lnk_sck_oe, lnk_sck_o} !== 4'b0001)
      $display("FAIL master_after: got %b required 0001", {done, busy, lnk_sck_oe, lnk_sck_o});
    else n_pass++;
    dmg_m_en = 1'b0;
  endtask

  task automatic test_slave(input logic [7:0] tx, input logic [7:0] dtx);
    int n;
    logic [7:0] drx;
    logic oe_bad;
    drx = 8'h00; oe_bad = 1'b0;
    kick(1'b0, tx);
    for (int i = 0; i < 8; i++) begin
      repeat (SlaveHalf) begin @(negedge clk1); if (lnk_sck_oe !== 1'b0) oe_bad = 1'b1; end
      lnk_sck_i = 1'b0; lnk_si = dtx[7-i];
      repeat (SlaveHalf) begin @(negedge clk1); if (lnk_sck_oe !== 1'b0) oe_bad = 1'b1; end
      drx = {drx[6:0], lnk_so}; lnk_sck_i = 1'b1;
    end
    wait_done(20, n);
    n_total++;
    if (done !== 1'b1) $display("FAIL slave_done: got %b required 1", done);
    else n_pass++;
    n_total++;
    if (rx_byte !== dtx) $display("FAIL slave_rx: got %h required %h", rx_byte, dtx);
    else n_pass++;
    n_total++;
    if (drx !== tx) $display("FAIL slave_dmg_rx: got %h required %h", drx, tx);
    else n_pass++;
    n_total++;
    if (oe_bad !== 1'b0) $display("FAIL slave_oe: got driven required released");
    else n_pass++;
    exp_rx = dtx;
    repeat (3) @(negedge clk1);
  endtask

  task automatic test_busy_start();
    int n;
    logic [7:0] tx, dtx;
    tx = 8'($urandom); dtx = 8'($urandom);
    done_cnt = 0;
    dmg_tx = dtx; dmg_rx = 8'h00; dmg_m_en = 1'b1;
    kick(1'b1, tx);
    repeat (10) @(negedge clk1);
    tx_byte = 8'hFF; start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    wait_done(200, n);
    n_total++;
    if (rx_byte !== dtx) $display("FAIL busy_start_rx: got %h required %h", rx_byte, dtx);
    else n_pass++;
    n_total++;
    if (dmg_rx !== tx) $display("FAIL busy_start_dmg_rx: got %h required %h", dmg_rx, tx);
    else n_pass++;
    exp_rx = dtx;
    repeat (20) @(negedge clk1);
    n_total++;
    if (done_cnt !== 1) $display("FAIL busy_start_done_count: got %0d required 1", done_cnt);
    else n_pass++;
    dmg_m_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    done_cnt = 0;
    dmg_tx = 8'h00; dmg_rx = 8'h00; dmg_m_en = 1'b1;
    kick(1'b1, 8'h00);
    repeat (25) @(posedge clk1);
    #1;
    n_total++;
    if ({busy, lnk_so, lnk_sck_oe} !== 3'b101)
      $display("FAIL reset_mid_pre: got %b required 101", {busy, lnk_so, lnk_sck_oe});
    else n_pass++;
    #1 nrst = 1'b0;
    #1;
    n_total++;
    if ({lnk_sck_oe, lnk_so, lnk_sck_o, busy} !== 4'b0110)
      $display("FAIL reset_mid_pins: got %b required 0110", {lnk_sck_oe, lnk_so, lnk_sck_o, busy});
    else n_pass++;
    dmg_m_en = 1'b0;
    repeat (3) @(negedge clk1);
    nrst = 1'b1;
    exp_rx = 8'h00;
    repeat (80) @(negedge clk1);
    n_total++;
    if (done_cnt !== 0) $display("FAIL reset_mid_no_done: got %0d required 0", done_cnt);
    else n_pass++;
    n_total++;
    if (rx_byte !== exp_rx) $display("FAIL reset_mid_rx: got %h required %h", rx_byte, exp_rx);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] d1, d2;
    d1 = 8'($urandom); d2 = 8'($urandom);
    dmg_tx = d1; dmg_rx = 8'h00; dmg_m_en = 1'b1;
    kick(1'b1, 8'h01);
    wait_done(200, n);
    n_total++;
    if (rx_byte !== d1 || dmg_rx !== 8'h01)
      $display("FAIL b2b_first: got rx %h dmg %h required rx %h dmg 01", rx_byte, dmg_rx, d1);
    else n_pass++;
    tx_byte = 8'h80; start = 1'b1; dmg_tx = d2; dmg_rx = 8'h00;
    @(posedge clk1); #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL b2b_start_in_done: got busy %b required 0", busy);
    else n_pass++;
    @(posedge clk1); #1;
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_start_after: got busy %b required 1", busy);
    else n_pass++;
    wait_done(200, n);
    n_total++;
    if (n < 64 || n > 66) $display("FAIL b2b_latency: got %0d required 64..66", n);
    else n_pass++;
    n_total++;
    if (rx_byte !== d2 || dmg_rx !== 8'h80)
      $display("FAIL b2b_second: got rx %h dmg %h required rx %h dmg 80", rx_byte, dmg_rx, d2);
    else n_pass++;
    exp_rx = d2;
    dmg_m_en = 1'b0;
    repeat (2) @(negedge clk1);
  endtask

  task automatic test_timeout();
    int n;
    logic [7:0] dtx;
    dtx = 8'($urandom);
    err_cnt = 0;
    kick(1'b0, 8'($urandom));
    for (int i = 0; i < 5; i++) begin
      repeat (SlaveHalf) @(negedge clk1);
      lnk_sck_i = 1'b0; lnk_si = dtx[7-i];
      repeat (SlaveHalf) @(negedge clk1);
      lnk_sck_i = 1'b1;
    end
    n = 0;
    while (err !== 1'b1 && n < 300) begin
      @(posedge clk1); #1;
      n++;
    end
`ifdef LINK_PARTNER_TIMEOUT_EN
    n_total++;
    if (n < 100 || n > 104) $display("FAIL timeout_latency: got %0d required 100..104", n);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL timeout_busy: got %b required 0", busy);
    else n_pass++;
    repeat (5) @(negedge clk1);
    n_total++;
    if (err_cnt !== 1) $display("FAIL timeout_err_count: got %0d required 1", err_cnt);
    else n_pass++;
`else
    n_total++;
    if (err_cnt !== 0 || busy !== 1'b1)
      $display("FAIL no_timeout_wait: got err %0d busy %b required err 0 busy 1", err_cnt, busy);
    else n_pass++;
`endif
    n_total++;
    if (rx_byte !== exp_rx) $display("FAIL timeout_rx_kept: got %h required %h", rx_byte, exp_rx);
    else n_pass++;
`ifndef LINK_PARTNER_TIMEOUT_EN
    @(negedge clk1); nrst = 1'b0;
    repeat (2) @(negedge clk1);
    nrst = 1'b1;
    exp_rx = 8'h00;
`endif
    repeat (2) @(negedge clk1);
  endtask

  initial begin
    test_reset();
    test_master(8'hA5, 8'h3C);
    for (int i = 0; i < 3; i++) test_master(8'($urandom), 8'($urandom));
    test_slave(8'h5A, 8'hC3);
    for (int i = 0; i < 2; i++) test_slave(8'($urandom), 8'($urandom));
    test_busy_start();
    test_reset_mid();
    test_master(8'($urandom), 8'($urandom));
    test_back_to_back();
    test_timeout();
    test_master(8'($urandom), 8'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
